// File: rtl/tc_array.sv
// tc_array: bank of NUM_CH memory-mapped countdown timers (one-shot / auto-reload) with sticky
// write-1-to-clear pending status; define TC_ARRAY_PRESCALE_EN to add a per-channel 8-bit divider.
module tc_array #(
    parameter int          NUM_CH    = 2,
    parameter int          CNT_W     = 32,
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       addr,
    input  logic              we,
    input  logic [31:0]       din,
    output logic [31:0]       dout,
    output logic [NUM_CH-1:0] irq,
    output logic              irq_any
);
    localparam logic [1:0]  ST_IDLE   = 2'd0;
    localparam logic [1:0]  ST_LOAD   = 2'd1;
    localparam logic [1:0]  ST_CNT    = 2'd2;
    localparam logic [1:0]  ST_INT    = 2'd3;
    localparam logic [1:0]  MODE_AUTO = 2'b01;
    localparam logic [31:0] SPAN      = 32'(16 * NUM_CH);

    logic [31:0]             rel;
    logic                    in_range;
    logic [1:0]              reg_sel;
    logic [NUM_CH-1:0]       ch_sel;
    logic [NUM_CH-1:0][31:0] rd_data;
    logic                    unused_bits;

    // Addresses below BASE_ADDR wrap to huge offsets and fall out of range.
    assign rel         = {addr[31:2], 2'b00} - BASE_ADDR;
    assign in_range    = (rel < SPAN);
    assign reg_sel     = rel[3:2];
    assign unused_bits = ^{addr[1:0], din};

    always_comb begin
        ch_sel = '0;
        for (int i = 0; i < NUM_CH; i++)
            ch_sel[i] = in_range && (rel[6:4] == 3'(i));
    end

    always_comb begin
        dout = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (ch_sel[i]) dout = rd_data[i];
    end

    assign irq_any = |irq;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [1:0]       state;
        logic             en;
        logic             im;
        logic             pend;
        logic [1:0]       mode;
        logic [CNT_W-1:0] preset;
        logic [CNT_W-1:0] count;
        logic [7:0]       prescale_rd;
        logic             tick;
        logic             expire;
        logic             wr_ctrl;
        logic             wr_preset;
        logic             w1c;
        logic             reload;

        assign wr_ctrl   = we && ch_sel[g] && (reg_sel == 2'd0);
        assign wr_preset = we && ch_sel[g] && (reg_sel == 2'd1);
        assign w1c       = we && ch_sel[g] && (reg_sel == 2'd3) && din[0];
        assign expire    = (state == ST_CNT) && en && tick && (count <= CNT_W'(1));
        // Auto-reload only continues if EN survives, including a CTRL write on this same edge.
        assign reload    = (mode == MODE_AUTO) && en && !(wr_ctrl && !din[0]);

`ifdef TC_ARRAY_PRESCALE_EN
        logic [7:0] prescale;
        logic [7:0] psc_cnt;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                prescale <= '0;
                psc_cnt  <= '0;
            end else begin
                if (wr_ctrl) prescale <= din[15:8];
                if (state == ST_LOAD)
                    psc_cnt <= '0;
                else if (state == ST_CNT && en)
                    psc_cnt <= tick ? 8'd0 : psc_cnt + 8'd1;
            end
        end

        assign tick        = (psc_cnt == prescale);
        assign prescale_rd = prescale;
`else
        assign tick        = 1'b1;
        assign prescale_rd = 8'd0;
`endif

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state  <= ST_IDLE;
                en     <= 1'b0;
                im     <= 1'b0;
                mode   <= '0;
                pend   <= 1'b0;
                preset <= '0;
                count  <= '0;
            end else begin
                case (state)
                    ST_IDLE: if (en) state <= ST_LOAD;
                    ST_LOAD: begin
                        count <= preset;
                        state <= ST_CNT;
                    end
                    ST_CNT: begin
                        if (!en) begin
                            state <= ST_IDLE;
                        end else if (tick) begin
                            if (count <= CNT_W'(1)) begin
                                count <= '0;
                                state <= ST_INT;
                            end else begin
                                count <= count - CNT_W'(1);
                            end
                        end
                    end
                    default: state <= reload ? ST_LOAD : ST_IDLE;
                endcase

                // A software CTRL write overrides the hardware one-shot EN clear.
                if (wr_ctrl) begin
                    en   <= din[0];
                    mode <= din[2:1];
                    im   <= din[3];
                end else if (state == ST_INT && mode != MODE_AUTO) begin
                    en <= 1'b0;
                end

                if (wr_preset) preset <= din[CNT_W-1:0];
                pend <= expire || (pend && !w1c);
            end
        end

        assign rd_data[g] = (reg_sel == 2'd0) ? {16'd0, prescale_rd, 4'd0, im, mode, en}
                          : (reg_sel == 2'd1) ? 32'(preset)
                          : (reg_sel == 2'd2) ? 32'(count)
                          : {31'd0, pend};
        assign irq[g] = pend && im;
    end
endmodule
